// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port between
// the single-cycle ALU path (source A) and the long-latency path (source B).
// Each source owns a 1-entry holding slot. Every cycle one occupied slot is
// granted and driven combinationally onto wb_*. pend_busy shows which
// registers still have a write in flight.
// Optional feature: define REGFILE_ARB_FWD_EN to add the fwd_rs/fwd_hit/
// fwd_data forwarding lookup. Without it, hazard logic stalls on pend_busy.
module regfile_write_arbiter #(
  parameter int XLEN         = 64,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [AW-1:0]       a_rd,
  input  logic [XLEN-1:0]     a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [AW-1:0]       b_rd,
  input  logic [XLEN-1:0]     b_data,
  output logic                wb_en,
  output logic [AW-1:0]       wb_rd,
  output logic [XLEN-1:0]     wb_data,
  output logic [(2**AW)-1:0]  pend_busy,
`ifdef REGFILE_ARB_FWD_EN
  input  logic [AW-1:0]       fwd_rs,
  output logic                fwd_hit,
  output logic [XLEN-1:0]     fwd_data,
`endif
  output logic [3:0]          b_starve_cnt
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);
  localparam logic [3:0] StarveMax   = 4'hF;

  // Slot state. aOlder/bOlder mark a slot that was loaded strictly before the
  // other currently occupied slot; both clear means loaded on the same edge.
  logic            aFull, bFull;
  logic            aOlder, bOlder;
  logic [AW-1:0]   aRdQ, bRdQ;
  logic [XLEN-1:0] aDataQ, bDataQ;
  logic [3:0]      starveCnt;

  logic grantA, grantB;
  logic aLoad, bLoad;

  // Arbitration: sole occupant, then age on equal rd, then starvation, then A.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    grantB = 1'b0;
    if (bFull) begin
      if (!aFull)                       grantB = 1'b1;
      else if (aRdQ == bRdQ)            grantB = !aOlder;  // tie on same edge goes to B
      else if (starveCnt == StarveLimit) grantB = 1'b1;
    end
    grantA = aFull && !grantB;
  end

  // A slot accepts when empty or draining this cycle; under reset both report ready.
  assign a_ready = reset || !aFull || grantA;
  assign b_ready = reset || !bFull || grantB;

  // Writes to x0 complete the handshake but never occupy a slot.
  assign aLoad = a_valid && a_ready && (a_rd != '0);
  assign bLoad = b_valid && b_ready && (b_rd != '0);

  // Occupancy, age bits and starve counter; reset discards held entries.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      aFull     <= 1'b0;
      bFull     <= 1'b0;
      aOlder    <= 1'b0;
      bOlder    <= 1'b0;
      starveCnt <= '0;
    end else begin
      // A fresh entry is never older than an entry already held.
      if (aLoad) begin
        aFull  <= 1'b1;
        aOlder <= 1'b0;
      end else if (grantA) begin
        aFull  <= 1'b0;
        aOlder <= 1'b0;
      end else if (aFull && bLoad) begin
        aOlder <= 1'b1;
      end

      if (bLoad) begin
        bFull  <= 1'b1;
        bOlder <= 1'b0;
      end else if (grantB) begin
        bFull  <= 1'b0;
        bOlder <= 1'b0;
      end else if (bFull && aLoad) begin
        bOlder <= 1'b1;
      end

      if (bFull && !grantB)
        starveCnt <= (starveCnt == StarveMax) ? StarveMax : starveCnt + 4'd1;
      else
        starveCnt <= '0;
    end
  end

  // Slot payload capture; only meaningful while the matching full bit is set.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are deliberately not reset; the full bits gate
    // every use, so clearing them would only add reset fanout.
    if (aLoad) begin
      aRdQ   <= a_rd;
      aDataQ <= a_data;
    end
    if (bLoad) begin
      bRdQ   <= b_rd;
      bDataQ <= b_data;
    end
  end

  // Write-port mux from the granted slot; zeros when idle or in reset.
  always_comb begin
    wb_en   = 1'b0;
    wb_rd   = '0;
    wb_data = '0;
    if (!reset) begin
      if (grantB) begin
        wb_en   = 1'b1;
        wb_rd   = bRdQ;
        wb_data = bDataQ;
      end else if (grantA) begin
        wb_en   = 1'b1;
        wb_rd   = aRdQ;
        wb_data = aDataQ;
      end
    end
  end

  // Pending-destination bitmap decoded from occupied slots; x0 never pends.
  always_comb begin
    pend_busy = '0;
    if (!reset) begin
      if (aFull) pend_busy[aRdQ] = 1'b1;
      if (bFull) pend_busy[bRdQ] = 1'b1;
      pend_busy[0] = 1'b0;
    end
  end

  assign b_starve_cnt = reset ? 4'd0 : starveCnt;

`ifdef REGFILE_ARB_FWD_EN
  logic aMatch, bMatch;

  assign aMatch = aFull && (aRdQ == fwd_rs);
  assign bMatch = bFull && (bRdQ == fwd_rs);

  // Forwarding lookup: the younger matching slot supplies the data. With both
  // loaded on the same edge A is younger, since B was issued first.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (!reset && (fwd_rs != '0) && (aMatch || bMatch)) begin
      fwd_hit  = 1'b1;
      fwd_data = (bMatch && (!aMatch || aOlder)) ? bDataQ : aDataQ;
    end
  end
`endif

endmodule
